bus_mem_responder: RTL and testbench

- Target end of the CPU memory bus: decodes Memread/Memwrite/Addr and answers on the shared bidirectional 32-bit BUS.
- Backed by a word RAM array.
- Includes a bus-idle-cycle DMA copy engine started by the Memwrite=2 (DMA) command.
- Drives the CPU's INTin/INTnum interrupt inputs when a DMA completes.

---
 rtl/bus_mem_responder_if.sv | 14 +
 rtl/bus_mem_responder.sv | 133 +++++++++++++
 tb/tb_bus_mem_responder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/bus_mem_responder_if.sv
// CPU memory-bus control and interrupt signals for bus_mem_responder.
// The data bus BUS is a separate inout port on the responder.
interface bus_mem_responder_if;
  logic        Memread;
  logic [1:0]  Memwrite;
  logic [31:0] Addr;
  logic        INTin;
  logic [31:0] INTnum;

  modport master (output Memread, output Memwrite, output Addr,
                  input INTin, input INTnum);
  modport slave  (input Memread, input Memwrite, input Addr,
                  output INTin, output INTnum);
endinterface

// File: rtl/bus_mem_responder.sv
// Memory-bus target: word RAM that answers on the shared BUS, with an optional
// idle-cycle DMA copy engine, status register and done interrupt (RESP_DMA_EN).
module bus_mem_responder #(
  parameter int          ADDR_W       = 10,
  parameter logic [31:0] STATUS_ADDR  = 32'hFFFF_FFF0,
  parameter logic [31:0] DMA_INT_CODE = 32'h0000_0020
) (
  input  logic                 clk,
  input  logic                 rst,
  inout  wire  [31:0]          BUS,
  bus_mem_responder_if.slave   cpu
);

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              is_status;
  logic              rd_en;
  logic              wr_word;
  logic              wr_byte;
  logic [31:0]       status;
  logic [31:0]       rd_data;
  logic              copy_go;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;

  // Word address ignores Addr[0]; upper bits alias. The status address never aliases into RAM.
  assign idx       = cpu.Addr[ADDR_W:1];
  assign is_status = (cpu.Addr == STATUS_ADDR);
  assign rd_en     = cpu.Memread && (cpu.Memwrite == 2'd0);
  assign wr_word   = (cpu.Memwrite == 2'd1) && !is_status;
  assign wr_byte   = (cpu.Memwrite == 2'd3) && !is_status;
  assign rd_data   = is_status ? status : mem[idx];
  assign BUS       = (rd_en && !rst) ? rd_data : 'z;

  // Single write port: CPU writes and DMA copies are mutually exclusive by construction.
  always_ff @(posedge clk) begin
    if (wr_word)
      mem[idx] <= BUS;
    else if (wr_byte)
      mem[idx][7:0] <= BUS[7:0];
    else if (copy_go)
      mem[dst] <= mem[src];
  end

`ifdef RESP_DMA_EN
  typedef enum logic [1:0] {IDLE, COPY, DONE} dma_state_t;

  dma_state_t        state;
  dma_state_t        state_nxt;
  logic [15:0]       remaining;
  logic [15:0]       remaining_nxt;
  logic [ADDR_W-1:0] src_nxt;
  logic [ADDR_W-1:0] dst_nxt;
  logic              overrun;
  logic              overrun_nxt;
  logic              dma_cmd;
  logic              cpu_access;
  logic              status_rd;

  assign dma_cmd    = (cpu.Memwrite == 2'd2);
  assign cpu_access = cpu.Memread || (cpu.Memwrite != 2'd0);
  assign status_rd  = cpu.Memread && is_status;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      src       <= '0;
      dst       <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      src       <= src_nxt;
      dst       <= dst_nxt;
      overrun   <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    src_nxt       = src;
    dst_nxt       = dst;
    overrun_nxt   = overrun;
    copy_go       = 1'b0;
    case (state)
      IDLE: begin
        if (dma_cmd) begin
          dst_nxt       = idx;
          src_nxt       = BUS[16 +: ADDR_W];
          remaining_nxt = BUS[15:0];
          state_nxt     = (BUS[15:0] == 16'd0) ? DONE : COPY;
        end
      end
      COPY: begin
        if (dma_cmd) begin
          overrun_nxt = 1'b1;
        end else if (!cpu_access) begin
          copy_go       = 1'b1;
          src_nxt       = src + 1'b1;
          dst_nxt       = dst + 1'b1;
          remaining_nxt = remaining - 16'd1;
          if (remaining == 16'd1)
            state_nxt = DONE;
        end
      end
      DONE: begin
        if (dma_cmd)
          overrun_nxt = 1'b1;
        // The acknowledging status read itself still sees done=1 and overrun.
        if (status_rd) begin
          state_nxt   = IDLE;
          overrun_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign status     = {(state == COPY), overrun, (state == DONE), 13'b0, remaining};
  assign cpu.INTin  = (state == DONE);
  assign cpu.INTnum = (state == DONE) ? DMA_INT_CODE : 32'h0;
`else
  assign copy_go    = 1'b0;
  assign src        = '0;
  assign dst        = '0;
  assign status     = 32'h0;
  assign cpu.INTin  = 1'b0;
  assign cpu.INTnum = 32'h0;
`endif

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: RAM access, aliasing, byte writes and,
// when RESP_DMA_EN is defined, the DMA engine, status register and interrupt.
module tb_bus_mem_responder;
  localparam logic [31:0] STATUS = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drv = 1'b0;
  logic [31:0] drv_val = '0;
  wire  [31:0] bus;
  int          total = 0;
  int          bad = 0;
  logic [31:0] d;
  logic [31:0] src_val [5];

  bus_mem_responder_if cpu_if();

  assign bus = drv ? drv_val : 'z;

  bus_mem_responder #(.ADDR_W(10), .STATUS_ADDR(STATUS), .DMA_INT_CODE(32'h20)) dut (
    .clk (clk),
    .rst (rst),
    .BUS (bus),
    .cpu (cpu_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    cpu_if.Memread  = 1'b0;
    cpu_if.Memwrite = 2'd0;
    cpu_if.Addr     = 32'h0;
    drv             = 1'b0;
  endtask

  task automatic wr(input logic [1:0] kind, input logic [31:0] a, input logic [31:0] v);
    cpu_if.Memwrite = kind;
    cpu_if.Addr     = a;
    drv_val         = v;
    drv             = 1'b1;
    tick(1);
    idle();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    cpu_if.Memread = 1'b1;
    cpu_if.Addr    = a;
    #1 v = bus;
    tick(1);
    idle();
  endtask

  initial begin
    src_val[0] = 32'h0123_4567;
    src_val[1] = 32'h89AB_CDEF;
    src_val[2] = 32'h5555_AAAA;
    src_val[3] = 32'hFFFF_0000;
    src_val[4] = 32'h0F0F_F0F0;
    idle();
    tick(2);
    chk("reset_intin", {31'b0, cpu_if.INTin}, 32'h0);
    chk("reset_intnum", cpu_if.INTnum, 32'h0);
    rst = 1'b0;
    tick(1);

    wr(2'd1, 32'd8, 32'hDEAD_BEEF);
    rd(32'd8, d);            chk("word_rd", d, 32'hDEAD_BEEF);
    rd(32'd9, d);            chk("word_rd_odd", d, 32'hDEAD_BEEF);
    rd(32'd8 + 32'd2048, d); chk("word_alias", d, 32'hDEAD_BEEF);
    wr(2'd1, 32'd4, 32'h1122_3344);
    wr(2'd3, 32'd4, 32'hAAAA_AA55);
    rd(32'd4, d);            chk("byte_wr", d, 32'h1122_3355);
    rd(32'd8, d);            chk("byte_no_neighbour", d, 32'hDEAD_BEEF);

    // Source words at index 8..12 live at addresses 16..24.
    for (int i = 0; i < 5; i++) wr(2'd1, 32'd16 + 32'(2 * i), src_val[i]);

`ifdef RESP_DMA_EN
    // 4-word copy: source index 8, destination index 32 (Addr 64).
    wr(2'd2, 32'd64, 32'h0008_0004);
    tick(3);
    chk("dma_intin_early", {31'b0, cpu_if.INTin}, 32'h0);
    tick(1);
    chk("dma_intin", {31'b0, cpu_if.INTin}, 32'h1);
    chk("dma_intnum", cpu_if.INTnum, 32'h20);
    rd(STATUS, d);           chk("dma_status_done", d, 32'h2000_0000);
    chk("dma_intin_cleared", {31'b0, cpu_if.INTin}, 32'h0);
    chk("dma_intnum_cleared", cpu_if.INTnum, 32'h0);
    for (int i = 0; i < 4; i++) begin
      rd(32'd64 + 32'(2 * i), d);
      chk($sformatf("dma_copy%0d", i), d, src_val[i]);
    end

    // Contention: 3-word copy to index 100, 2 stall reads, then an overrun command.
    wr(2'd1, 32'd300, 32'h7777_1111);
    wr(2'd2, 32'd200, 32'h0008_0003);
    cpu_if.Memread = 1'b1;
    cpu_if.Addr    = STATUS;
    #1 chk("cont_status_busy", bus, 32'h8000_0003);
    tick(1);
    #1 chk("cont_status_stalled", bus, 32'h8000_0003);
    tick(1);
    idle();
    wr(2'd2, 32'd300, 32'h0000_0001);
    tick(2);
    chk("cont_intin_early", {31'b0, cpu_if.INTin}, 32'h0);
    tick(1);
    chk("cont_intin", {31'b0, cpu_if.INTin}, 32'h1);
    rd(STATUS, d);           chk("cont_status_overrun", d, 32'h6000_0000);
    chk("cont_intin_cleared", {31'b0, cpu_if.INTin}, 32'h0);
    rd(STATUS, d);           chk("cont_status_idle", d, 32'h0);
    for (int i = 0; i < 3; i++) begin
      rd(32'd200 + 32'(2 * i), d);
      chk($sformatf("cont_copy%0d", i), d, src_val[i]);
    end
    rd(32'd300, d);          chk("cont_no_restart", d, 32'h7777_1111);

    // Zero-count command goes straight to DONE and moves nothing.
    wr(2'd1, 32'd400, 32'h1234_5678);
    wr(2'd2, 32'd400, 32'h0008_0000);
    chk("zero_intin", {31'b0, cpu_if.INTin}, 32'h1);
    chk("zero_intnum", cpu_if.INTnum, 32'h20);
    rd(32'd400, d);          chk("zero_ram", d, 32'h1234_5678);
    rd(STATUS, d);           chk("zero_status", d, 32'h2000_0000);
    chk("zero_intin_cleared", {31'b0, cpu_if.INTin}, 32'h0);

    // Reset after 2 of 5 words: destination index 300..304 (Addr 600..608).
    for (int i = 0; i < 5; i++) wr(2'd1, 32'd600 + 32'(2 * i), 32'hCAFE_0000 + 32'(i));
    wr(2'd2, 32'd600, 32'h0008_0005);
    tick(2);
    rst = 1'b1;
    #2;
    chk("rst_intin", {31'b0, cpu_if.INTin}, 32'h0);
    chk("rst_intnum", cpu_if.INTnum, 32'h0);
    tick(2);
    rst = 1'b0;
    tick(4);
    rd(STATUS, d);           chk("rst_status", d, 32'h0);
    chk("rst_intin_after", {31'b0, cpu_if.INTin}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      rd(32'd600 + 32'(2 * i), d);
      chk($sformatf("rst_word%0d", i), d, (i < 2) ? src_val[i] : 32'hCAFE_0000 + 32'(i));
    end
`else
    wr(2'd1, 32'd64, 32'h3333_4444);
    wr(2'd2, 32'd64, 32'h0008_0001);
    tick(3);
    rd(32'd64, d);           chk("nodma_ram", d, 32'h3333_4444);
    chk("nodma_intin", {31'b0, cpu_if.INTin}, 32'h0);
    chk("nodma_intnum", cpu_if.INTnum, 32'h0);
    rd(STATUS, d);           chk("nodma_status", d, 32'h0);
    wr(2'd1, STATUS, 32'h9999_9999);
    rd(32'd16, d);           chk("nodma_src_intact", d, src_val[0]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
